// File: rtl/env_pkg.sv
// -----------------------------------------------------------------------------
// env_pkg
// Shared definitions for the polyphonic ADSR envelope generator:
//   - default level / time widths and voice count
//   - one-hot envelope state encoding used by every voice
// -----------------------------------------------------------------------------
package env_pkg;

    localparam int VOICES_DEF = 4;   // default number of envelope channels
    localparam int VW_DEF     = 18;  // default level width
    localparam int TW_DEF     = 32;  // default time / counter width

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_ATTACK  = 5'b00010,
        ST_DECAY   = 5'b00100,
        ST_SUSTAIN = 5'b01000,
        ST_RELEASE = 5'b10000
    } env_state_e;

endpackage

// File: rtl/env_voice.sv
// -----------------------------------------------------------------------------
// env_voice
// One ADSR envelope channel: state machine, segment counter, segment start
// level, linear interpolator with clamp, and registered outputs.
//
// Ports:
//   clk        clock
//   rst_b      asynchronous active-low reset
//   note_on_i  start / retrigger request (wins over note_off_i)
//   note_off_i release request (ignored in IDLE and RELEASE)
//   a_i..d_i   idle, peak, sustain and release-end levels
//   x_i..z_i   attack, decay and release durations in cycles (0 acts as 1)
//   level_o    registered envelope level, one cycle behind the state
//   busy_o     registered, high while the voice was not IDLE
//   done_o     registered one-cycle pulse when release has finished
// -----------------------------------------------------------------------------
module env_voice
    import env_pkg::*;
#(
    parameter int VW = VW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          note_on_i,
    input  logic          note_off_i,
    input  logic [VW-1:0] a_i,
    input  logic [VW-1:0] b_i,
    input  logic [VW-1:0] c_i,
    input  logic [VW-1:0] d_i,
    input  logic [TW-1:0] x_i,
    input  logic [TW-1:0] y_i,
    input  logic [TW-1:0] z_i,
    output logic [VW-1:0] level_o,
    output logic          busy_o,
    output logic          done_o
);

    // Product width: TW-bit counter times (VW+1)-bit signed difference.
    localparam int PW = TW + VW + 1;

    env_state_e    state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [VW-1:0] sv_q, sv_d;
    logic [VW-1:0] level_q;
    logic          busy_q;
    logic          done_q;
    logic          rel_end_q, rel_end_d;

    // Segment being traversed in the current state.
    logic [VW-1:0] seg_from, seg_to;
    logic [TW-1:0] seg_len, dur;
    logic          seg_ramp;

    always_comb begin
        seg_from = a_i;
        seg_to   = a_i;
        seg_len  = '0;
        seg_ramp = 1'b0;
        case (state_q)
            ST_ATTACK: begin
                seg_from = sv_q;
                seg_to   = b_i;
                seg_len  = x_i;
                seg_ramp = 1'b1;
            end
            ST_DECAY: begin
                seg_from = b_i;
                seg_to   = c_i;
                seg_len  = y_i;
                seg_ramp = 1'b1;
            end
            ST_RELEASE: begin
                seg_from = sv_q;
                seg_to   = d_i;
                seg_len  = z_i;
                seg_ramp = 1'b1;
            end
            ST_SUSTAIN: begin
                seg_from = c_i;
                seg_to   = c_i;
            end
            default: ;
        endcase
    end

    // A zero-length segment is treated as a single cycle.
    assign dur = (seg_len == '0) ? TW'(1) : seg_len;

    // Interpolation: from + cnt*(to-from)/dur, signed, truncating toward zero.
    // Settings may change mid-segment, so the result is clamped to range.
    logic signed [VW:0]   diff;
    logic signed [PW-1:0] prod, quot, sum;
    logic [VW-1:0]        level;

    always_comb begin
        diff = $signed({1'b0, seg_to}) - $signed({1'b0, seg_from});
        prod = $signed({{(PW-TW){1'b0}}, cnt_q}) * $signed({{TW{diff[VW]}}, diff});
        quot = prod / $signed({{(PW-TW){1'b0}}, dur});
        sum  = $signed({{(PW-VW){1'b0}}, seg_from}) + quot;
        if (!seg_ramp) begin
            level = seg_from;
        end else if (sum[PW-1]) begin
            level = '0;
        end else if (sum > $signed({{(PW-VW){1'b0}}, {VW{1'b1}}})) begin
            level = '1;
        end else begin
            level = sum[VW-1:0];
        end
    end

    // Counter widened by one bit so counter+1 cannot wrap.
    logic timeout;
    assign timeout = ({1'b0, cnt_q} + {{TW{1'b0}}, 1'b1}) >= {1'b0, dur};

    always_comb begin
        state_d   = state_q;
        sv_d      = sv_q;
        rel_end_d = 1'b0;
        cnt_d     = (state_q == ST_IDLE) ? '0 : cnt_q + TW'(1);
        if (note_on_i) begin
            // Retrigger starts the attack from wherever the level is now.
            state_d = ST_ATTACK;
            sv_d    = (state_q == ST_IDLE) ? a_i : level;
            cnt_d   = '0;
        end else if (note_off_i && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                                    state_q == ST_SUSTAIN)) begin
            state_d = ST_RELEASE;
            sv_d    = level;
            cnt_d   = '0;
        end else if (seg_ramp && timeout) begin
            cnt_d = '0;
            case (state_q)
                ST_ATTACK: state_d = ST_DECAY;
                ST_DECAY:  state_d = ST_SUSTAIN;
                default: begin
                    state_d   = ST_IDLE;
                    rel_end_d = 1'b1;
                end
            endcase
        end
    end

    // rel_end_q marks the first IDLE cycle after a release; done follows one
    // cycle later so it lines up with the registered level showing a.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sv_q      <= '0;
            level_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rel_end_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sv_q      <= sv_d;
            level_q   <= level;
            busy_q    <= (state_q != ST_IDLE);
            done_q    <= rel_end_q;
            rel_end_q <= rel_end_d;
        end
    end

    assign level_o = level_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: rtl/env_gen_poly.sv
// -----------------------------------------------------------------------------
// env_gen_poly
// Polyphonic ADSR envelope generator: VOICES independent env_voice channels
// sharing one set of level and time settings.
//
// Ports:
//   clk        clock
//   rst_b      asynchronous active-low reset
//   note_on    per-voice start / retrigger request
//   note_off   per-voice release request
//   a, b, c, d idle, peak, sustain, release-end levels (VW bits)
//   x, y, z    attack, decay, release durations in cycles (TW bits)
//   out_value  packed registered levels, voice v at [v*VW +: VW]
//   busy       registered per-voice activity flag
//   done       registered per-voice release-complete pulse
// -----------------------------------------------------------------------------
module env_gen_poly
    import env_pkg::*;
#(
    parameter int VOICES = VOICES_DEF,
    parameter int VW     = VW_DEF,
    parameter int TW     = TW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [VOICES-1:0]    note_on,
    input  logic [VOICES-1:0]    note_off,
    input  logic [VW-1:0]        a,
    input  logic [VW-1:0]        b,
    input  logic [VW-1:0]        c,
    input  logic [VW-1:0]        d,
    input  logic [TW-1:0]        x,
    input  logic [TW-1:0]        y,
    input  logic [TW-1:0]        z,
    output logic [VOICES*VW-1:0] out_value,
    output logic [VOICES-1:0]    busy,
    output logic [VOICES-1:0]    done
);

    generate
        for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
            env_voice #(
                .VW (VW),
                .TW (TW)
            ) u_voice (
                .clk        (clk),
                .rst_b      (rst_b),
                .note_on_i  (note_on[gi]),
                .note_off_i (note_off[gi]),
                .a_i        (a),
                .b_i        (b),
                .c_i        (c),
                .d_i        (d),
                .x_i        (x),
                .y_i        (y),
                .z_i        (z),
                .level_o    (out_value[gi*VW +: VW]),
                .busy_o     (busy[gi]),
                .done_o     (done[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_env_gen_poly.sv
// -----------------------------------------------------------------------------
// tb_env_gen_poly
// Self-checking bench for env_gen_poly (2 voices). Directed envelope scenarios
// followed by randomized note traffic and settings, compared cycle by cycle
// against a behavioural ADSR model.
// -----------------------------------------------------------------------------
module tb_env_gen_poly;

    localparam int     VOICES = 2;
    localparam int     VW     = 18;
    localparam int     TW     = 32;
    localparam longint LMAX   = 262143;  // 2^18 - 1

    logic                 clk = 1'b0;
    logic                 rst_b = 1'b0;
    logic [VOICES-1:0]    note_on = '0;
    logic [VOICES-1:0]    note_off = '0;
    logic [VW-1:0]        a, b, c, d;
    logic [TW-1:0]        x, y, z;
    logic [VOICES*VW-1:0] out_value;
    logic [VOICES-1:0]    busy;
    logic [VOICES-1:0]    done;

    int n_tests = 0;
    int n_fail  = 0;

    env_gen_poly #(
        .VOICES (VOICES),
        .VW     (VW),
        .TW     (TW)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .note_on   (note_on),
        .note_off  (note_off),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .x         (x),
        .y         (y),
        .z         (z),
        .out_value (out_value),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
    int     m_ph[VOICES];
    longint m_n[VOICES];      // cycles spent in current phase
    longint m_s[VOICES];      // level the current ramp started from
    bit     m_fresh[VOICES];  // first idle cycle after a finished release

    function automatic longint lerp(longint s, longint e, longint n, longint t);
        longint dd, r;
        dd = (t == 0) ? 1 : t;
        r  = s + (n * (e - s)) / dd;
        if (r < 0)    r = 0;
        if (r > LMAX) r = LMAX;
        return r;
    endfunction

    function automatic longint phase_len(int ph);
        case (ph)
            1:       return longint'(x);
            2:       return longint'(y);
            default: return longint'(z);
        endcase
    endfunction

    function automatic longint model_level(int v);
        case (m_ph[v])
            1:       return lerp(m_s[v], longint'(b), m_n[v], longint'(x));
            2:       return lerp(longint'(b), longint'(c), m_n[v], longint'(y));
            3:       return longint'(c);
            4:       return lerp(m_s[v], longint'(d), m_n[v], longint'(z));
            default: return longint'(a);
        endcase
    endfunction

    function automatic void model_step(int v, bit on, bit off);
        longint lvl, t;
        lvl = model_level(v);
        m_fresh[v] = 1'b0;
        if (on) begin
            m_s[v]  = (m_ph[v] == 0) ? longint'(a) : lvl;
            m_ph[v] = 1;
            m_n[v]  = 0;
        end else if (off && m_ph[v] >= 1 && m_ph[v] <= 3) begin
            m_s[v]  = lvl;
            m_ph[v] = 4;
            m_n[v]  = 0;
        end else if (m_ph[v] == 1 || m_ph[v] == 2 || m_ph[v] == 4) begin
            t = phase_len(m_ph[v]);
            if (t == 0) t = 1;
            if (m_n[v] + 1 >= t) begin
                if (m_ph[v] == 4) m_fresh[v] = 1'b1;
                m_ph[v] = (m_ph[v] == 1) ? 2 : (m_ph[v] == 2) ? 3 : 0;
                m_n[v]  = 0;
            end else begin
                m_n[v]++;
            end
        end else if (m_ph[v] == 3) begin
            m_n[v]++;
        end else begin
            m_n[v] = 0;
        end
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VOICES; v++) begin
            m_ph[v]    = 0;
            m_n[v]     = 0;
            m_s[v]     = 0;
            m_fresh[v] = 1'b0;
        end
    endtask

    function automatic longint dut_out(int v);
        return longint'(out_value[v*VW +: VW]);
    endfunction

    // One clock: predict outputs from the pre-edge model state, advance the
    // model with the sampled requests, then compare just after the edge.
    task automatic tick();
        longint e_out[VOICES];
        bit     e_busy[VOICES];
        bit     e_done[VOICES];
        for (int v = 0; v < VOICES; v++) begin
            e_out[v]  = model_level(v);
            e_busy[v] = (m_ph[v] != 0);
            e_done[v] = m_fresh[v];
            model_step(v, note_on[v], note_off[v]);
        end
        @(posedge clk);
        #1;
        for (int v = 0; v < VOICES; v++) begin
            chk($sformatf("out%0d", v), 64'(dut_out(v)), 64'(e_out[v]));
            chk($sformatf("busy%0d", v), 64'(busy[v]), 64'(e_busy[v]));
            chk($sformatf("done%0d", v), 64'(done[v]), 64'(e_done[v]));
        end
    endtask

    task automatic set_default();
        a = 18'd0;  b = 18'd1000; c = 18'd500; d = 18'd0;
        x = 32'd10; y = 32'd5;    z = 32'd4;
    endtask

    initial begin
        set_default();
        model_reset();

        // ---- reset state ----
        #12;
        chk("rst_out", 64'(out_value), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_b = 1'b1;
        tick();

        // ---- full envelope ----
        $display("[TB] full envelope on voice 0");
        note_on = 2'b01; tick(); note_on = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("attack", 64'(dut_out(0)), 64'(i * 100));
            chk("attack_busy", 64'(busy[0]), 64'd1);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("decay", 64'(dut_out(0)), 64'(1000 - 100 * i));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sustain", 64'(dut_out(0)), 64'd500);
            chk("v1_out", 64'(dut_out(1)), 64'd0);
            chk("v1_busy", 64'(busy[1]), 64'd0);
        end

        // ---- release from sustain ----
        $display("[TB] release from sustain on voice 0");
        note_off = 2'b01; tick(); note_off = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("release", 64'(dut_out(0)), 64'(500 - 125 * i));
            chk("release_done", 64'(done[0]), 64'd0);
        end
        tick();
        chk("rel_end_out", 64'(dut_out(0)), 64'd0);
        chk("rel_end_done", 64'(done[0]), 64'd1);
        chk("rel_end_busy", 64'(busy[0]), 64'd0);
        tick();
        chk("done_once", 64'(done[0]), 64'd0);

        // ---- early release during attack ----
        $display("[TB] early release on voice 0");
        note_on = 2'b01; tick(); note_on = '0;
        for (int i = 0; i < 5; i++) tick();
        note_off = 2'b01; tick(); note_off = '0;
        chk("early_l", 64'(dut_out(0)), 64'd500);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("early_rel", 64'(dut_out(0)), 64'(500 - 125 * i));
        end
        tick();
        chk("early_done", 64'(done[0]), 64'd1);
        tick();

        // ---- retrigger during release ----
        $display("[TB] retrigger on voice 0");
        note_on = 2'b01; tick(); note_on = '0;
        for (int i = 0; i < 20; i++) tick();
        note_off = 2'b01; tick(); note_off = '0;
        tick(); tick();
        note_on = 2'b01; tick(); note_on = '0;
        chk("retrig_l", 64'(dut_out(0)), 64'd250);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("retrig_att", 64'(dut_out(0)), 64'(250 + 75 * i));
            chk("retrig_done", 64'(done[0]), 64'd0);
        end
        tick();
        chk("retrig_peak", 64'(dut_out(0)), 64'd1000);
        for (int i = 0; i < 6; i++) tick();

        // ---- simultaneous on/off with zero attack ----
        $display("[TB] simultaneous on/off, x=0, voice 1");
        x = 32'd0;
        note_on = 2'b10; note_off = 2'b10; tick(); note_on = '0; note_off = '0;
        tick();
        chk("zero_att", 64'(dut_out(1)), 64'd0);
        chk("zero_busy", 64'(busy[1]), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("zero_decay", 64'(dut_out(1)), 64'(1000 - 100 * i));
        end
        x = 32'd10;
        for (int i = 0; i < 4; i++) tick();

        // ---- asynchronous reset mid-attack ----
        $display("[TB] async reset during attack");
        note_on = 2'b11; tick(); note_on = '0;
        tick(); tick();
        #2 rst_b = 1'b0;
        #1;
        chk("arst_out", 64'(out_value), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        model_reset();
        #3 rst_b = 1'b1;
        tick();
        chk("post_rst_out", 64'(out_value), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);

        // ---- randomized traffic ----
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 50 == 0) begin
                a = VW'($urandom_range(0, 262143));
                b = VW'($urandom_range(0, 262143));
                c = VW'($urandom_range(0, 262143));
                d = VW'($urandom_range(0, 262143));
                x = $urandom_range(0, 12);
                y = $urandom_range(0, 12);
                z = $urandom_range(0, 12);
                $display("[TB] cyc %0d settings a=%0d b=%0d c=%0d d=%0d x=%0d y=%0d z=%0d",
                         cyc, a, b, c, d, x, y, z);
            end
            for (int v = 0; v < VOICES; v++) begin
                note_on[v]  = ($urandom_range(0, 15) == 0);
                note_off[v] = ($urandom_range(0, 11) == 0);
            end
            if (note_on != '0 || note_off != '0)
                $display("[TB] cyc %0d note_on=%b note_off=%b", cyc, note_on, note_off);
            tick();
        end
        note_on  = '0;
        note_off = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
